l2_set_buf_queue: RTL
=====================

Name: l2_set_buf_queue

Overview:
Parametrised successor to the L2 single-snapshot way buffers. Holds up to DEPTH snapshots of a set read: all ways' line, tag, hprot and state, plus the evict way and the set index. Snapshots leave in FIFO order, and an in-flight write to a matching set/way keeps buffered copies coherent. Sits between the L2 tag/data/state RAM read port and the L2 FSM.

Parameters:
DEPTH, 2, number of snapshot entries (1..8)
WAYS, `L2_WAYS, ways per snapshot
OVERWRITE, 0, 1: push when full replaces the newest entry instead of being dropped

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries
rd_mem_en  in  1  push snapshot
rd_set  in  l2_set_t  set index of the pushed snapshot
rd_data_line  in  line_t[WAYS]  read lines
rd_data_tag  in  l2_tag_t[WAYS]  read tags
rd_data_hprot  in  hprot_t[WAYS]  read hprots
rd_data_state  in  state_t[WAYS]  read states
rd_data_evict_way  in  l2_way_t  read evict way
buf_pop  in  1  consume head entry
wr_en  in  1  RAM write in progress
wr_set  in  l2_set_t  write set
wr_way  in  l2_way_t  write way
wr_line  in  line_t  write line
wr_tag  in  l2_tag_t  write tag
wr_hprot  in  hprot_t  write hprot
wr_state  in  state_t  write state
buf_valid  out  1  head entry valid
buf_set  out  l2_set_t  head set index
evict_way_buf  out  l2_way_t  head evict way
lines_buf  out  line_t[WAYS]  head lines
tags_buf  out  l2_tag_t[WAYS]  head tags
hprots_buf  out  hprot_t[WAYS]  head hprots
states_buf  out  state_t[WAYS]  head states
buf_count  out  $clog2(DEPTH+1)  occupied entries
buf_full  out  1  buf_count==DEPTH
overflow  out  1  sticky: a push was dropped

Behaviour:
- Clock is clk; reset rst is asynchronous, active-low. On reset: all entry storage, head/tail pointers, buf_count and overflow are 0. buf_valid=0 and all head outputs are 0.
- Head outputs are combinational from the head entry. They are 0 when the buffer is empty.
- Push: on rd_mem_en, write the snapshot to the tail at the clock edge. It is visible at the head (if the buffer was empty) in the following cycle, giving 1-cycle latency, the same as the legacy buffer.
- Pop: on buf_pop with buf_valid, advance the head. buf_pop while empty is ignored.
- Push and pop in the same cycle: both take effect and buf_count is unchanged. This is also allowed when full, because the pop frees the slot.
- Push when full without pop:
  - OVERWRITE=0: the push is dropped and overflow is set. overflow clears only on reset or flush.
  - OVERWRITE=1: the newest entry (tail-1) is replaced, buf_count stays DEPTH, and overflow is not set.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of 2.
- Coherence update: on wr_en, every valid entry with set==wr_set has way wr_way's line, tag, hprot and state replaced with the wr_* values at the clock edge.
- If a push in the same cycle has rd_set==wr_set, the wr_* values replace way wr_way of the pushed data before storage (write wins).
- An entry popped in the same cycle is not updated; this is harmless.
- evict_way is never modified by wr_en.
- flush: all entries invalid, count 0, overflow 0. flush has priority over push, pop and wr_en in the same cycle.
- Legacy mode: DEPTH=1, OVERWRITE=1, buf_pop tied 0. Every rd_mem_en replaces the single entry, which matches the existing single-register behaviour plus buf_valid.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Decomposition:
- l2_set_t, l2_way_t, line_t, l2_tag_t, hprot_t and state_t remain in the shared cache types package.
- Add an l2_snapshot_t struct (set, evict_way, per-way line/tag/hprot/state) to the same package.
- One sub-module is natural: l2_snapshot_merge, the combinational wr_* overlay onto a snapshot for a given set/way. It is instantiated once for the push path and once per entry.

Test Plan:
- Reset, then push set 5 with tags{1..8}, evict 3 -> next cycle buf_valid=1, buf_set=5, tags_buf[2]=3, evict_way_buf=3, buf_count=1.
- DEPTH=2: push sets 1, 2, 3 with no pop -> third push dropped, overflow=1, head set 1. Pop -> head set 2. Pop -> buf_valid=0, outputs 0.
- Buffered set 7; wr_en set 7 way 2 line 0xAB state 3 -> lines_buf[2]=0xAB, states_buf[2]=3, other ways unchanged. wr_en on set 8 -> no change.
- Same-cycle push set 4 and wr_en set 4 way 0 tag 0x9 -> stored tags_buf[0]=0x9.
- Full, then push+pop in the same cycle -> count stays 2, order preserved. flush together with a push -> count 0, overflow 0.
- DEPTH=1, OVERWRITE=1: push A then B on consecutive cycles -> head shows B, overflow=0. Assert rst asynchronously mid-stream -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/l2_set_buf_queue_pkg.sv
// Shared L2 cache types plus the buffered set-read snapshot record.
package l2_set_buf_queue_pkg;

  localparam int L2_WAYS     = 8;
  localparam int L2_SET_BITS = 4;
  localparam int L2_WAY_BITS = 3;
  localparam int L2_TAG_BITS = 8;
  localparam int LINE_BITS   = 32;
  localparam int HPROT_BITS  = 1;
  localparam int STATE_BITS  = 3;

  typedef logic [L2_SET_BITS-1:0] l2_set_t;
  typedef logic [L2_WAY_BITS-1:0] l2_way_t;
  typedef logic [L2_TAG_BITS-1:0] l2_tag_t;
  typedef logic [LINE_BITS-1:0]   line_t;
  typedef logic [HPROT_BITS-1:0]  hprot_t;
  typedef logic [STATE_BITS-1:0]  state_t;

  typedef struct packed {
    l2_set_t                  set_idx;
    l2_way_t                  evict_way;
    line_t   [L2_WAYS-1:0]    line;
    l2_tag_t [L2_WAYS-1:0]    tag;
    hprot_t  [L2_WAYS-1:0]    hprot;
    state_t  [L2_WAYS-1:0]    state;
  } l2_snapshot_t;

endpackage

// File: rtl/l2_set_buf_queue_merge.sv
// Overlays an in-flight RAM write onto one snapshot when the set matches.
module l2_snapshot_merge
  import l2_set_buf_queue_pkg::*;
(
  input  l2_snapshot_t snap_in,
  input  logic         wr_en,
  input  l2_set_t      wr_set,
  input  l2_way_t      wr_way,
  input  line_t        wr_line,
  input  l2_tag_t      wr_tag,
  input  hprot_t       wr_hprot,
  input  state_t       wr_state,
  output l2_snapshot_t snap_out
);

  // evict_way is deliberately left untouched; only the written way changes.
  always_comb begin
    snap_out = snap_in;
    if (wr_en && (snap_in.set_idx == wr_set) && (int'(wr_way) < L2_WAYS)) begin
      snap_out.line[wr_way]  = wr_line;
      snap_out.tag[wr_way]   = wr_tag;
      snap_out.hprot[wr_way] = wr_hprot;
      snap_out.state[wr_way] = wr_state;
    end
  end

endmodule

// File: rtl/l2_set_buf_queue.sv
// FIFO of L2 set-read snapshots kept coherent with concurrent RAM writes.
module l2_set_buf_queue
  import l2_set_buf_queue_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int WAYS      = L2_WAYS,
  parameter bit OVERWRITE = 1'b0,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             rd_mem_en,
  input  l2_set_t          rd_set,
  input  line_t            rd_data_line [WAYS],
  input  l2_tag_t          rd_data_tag [WAYS],
  input  hprot_t           rd_data_hprot [WAYS],
  input  state_t           rd_data_state [WAYS],
  input  l2_way_t          rd_data_evict_way,
  input  logic             buf_pop,
  input  logic             wr_en,
  input  l2_set_t          wr_set,
  input  l2_way_t          wr_way,
  input  line_t            wr_line,
  input  l2_tag_t          wr_tag,
  input  hprot_t           wr_hprot,
  input  state_t           wr_state,
  output logic             buf_valid,
  output l2_set_t          buf_set,
  output l2_way_t          evict_way_buf,
  output line_t            lines_buf [WAYS],
  output l2_tag_t          tags_buf [WAYS],
  output hprot_t           hprots_buf [WAYS],
  output state_t           states_buf [WAYS],
  output logic [CNT_W-1:0] buf_count,
  output logic             buf_full,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  l2_snapshot_t     entries [DEPTH];
  l2_snapshot_t     merged [DEPTH];
  l2_snapshot_t     push_raw;
  l2_snapshot_t     push_snap;
  ptr_t             head;
  ptr_t             tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] valid;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic             push_ovw;
  logic             push_drop;
  int               off;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  function automatic ptr_t ptr_dec(input ptr_t p);
    return (p == '0) ? ptr_t'(DEPTH - 1) : ptr_t'(p - 1'b1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop_ok    = buf_pop && !empty;
  assign push_ok   = rd_mem_en && (!full || pop_ok);
  assign push_ovw  = OVERWRITE && rd_mem_en && full && !pop_ok;
  assign push_drop = !OVERWRITE && rd_mem_en && full && !pop_ok;

  always_comb begin
    push_raw           = '0;
    push_raw.set_idx   = rd_set;
    push_raw.evict_way = rd_data_evict_way;
    for (int w = 0; w < WAYS; w++) begin
      push_raw.line[w]  = rd_data_line[w];
      push_raw.tag[w]   = rd_data_tag[w];
      push_raw.hprot[w] = rd_data_hprot[w];
      push_raw.state[w] = rd_data_state[w];
    end
  end

  // An entry is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    off   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = (i >= int'(head)) ? (i - int'(head)) : (i + DEPTH - int'(head));
      valid[i] = (off < int'(count));
    end
  end

  l2_snapshot_merge u_push_merge (
    .snap_in (push_raw), .wr_en (wr_en), .wr_set (wr_set), .wr_way (wr_way),
    .wr_line (wr_line), .wr_tag (wr_tag), .wr_hprot (wr_hprot), .wr_state (wr_state),
    .snap_out(push_snap)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    l2_snapshot_merge u_entry_merge (
      .snap_in (entries[g]), .wr_en (wr_en), .wr_set (wr_set), .wr_way (wr_way),
      .wr_line (wr_line), .wr_tag (wr_tag), .wr_hprot (wr_hprot), .wr_state (wr_state),
      .snap_out(merged[g])
    );
  end

  // The push writes after the coherence refresh so it wins on a shared slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) entries[i] <= merged[i];
      end
      if (push_ok) begin
        entries[tail] <= push_snap;
        tail          <= ptr_inc(tail);
      end else if (push_ovw) begin
        entries[ptr_dec(tail)] <= push_snap;
      end
      if (pop_ok) head <= ptr_inc(head);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      if (push_drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    buf_valid     = !empty;
    buf_set       = '0;
    evict_way_buf = '0;
    for (int w = 0; w < WAYS; w++) begin
      lines_buf[w]  = '0;
      tags_buf[w]   = '0;
      hprots_buf[w] = '0;
      states_buf[w] = '0;
    end
    if (!empty) begin
      buf_set       = entries[head].set_idx;
      evict_way_buf = entries[head].evict_way;
      for (int w = 0; w < WAYS; w++) begin
        lines_buf[w]  = entries[head].line[w];
        tags_buf[w]   = entries[head].tag[w];
        hprots_buf[w] = entries[head].hprot[w];
        states_buf[w] = entries[head].state[w];
      end
    end
  end

  assign buf_count = count;
  assign buf_full  = full;

endmodule
